// File: rtl/axi_lsu_master.sv
// axi_lsu_master: AXI4-Lite master for the RV32I core load/store port.
// Accepts one core request at a time and runs either a write (AW+W, then B)
// or a read (AR, then R). Completion is reported with a one-cycle mem_done
// pulse carrying mem_err (nonzero response or timeout) and, for loads, mem_rdata.
// Ports:
//   AXI_ACLK, AXI_ARESETN        clock, synchronous active-low reset
//   mem_valid/mem_ready          core request handshake (mem_ready = IDLE)
//   mem_we, mem_addr, mem_wdata, mem_wstrb   request payload
//   mem_rdata, mem_done, mem_err completion report
//   AXI_AW*/AXI_W*/AXI_B*        write channels
//   AXI_AR*/AXI_R*               read channels
module axi_lsu_master #(
    parameter int unsigned AXI_AWIDTH     = 32,
    parameter int unsigned AXI_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_we,
    input  logic [AXI_AWIDTH-1:0]     mem_addr,
    input  logic [AXI_DWIDTH-1:0]     mem_wdata,
    input  logic [AXI_DWIDTH/8-1:0]   mem_wstrb,
    output logic [AXI_DWIDTH-1:0]     mem_rdata,
    output logic                      mem_done,
    output logic                      mem_err,
    output logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
    output logic                      AXI_AWVALID,
    input  logic                      AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]     AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
    output logic                      AXI_WVALID,
    input  logic                      AXI_WREADY,
    input  logic [1:0]                AXI_BRESP,
    input  logic                      AXI_BVALID,
    output logic                      AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
    output logic                      AXI_ARVALID,
    input  logic                      AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                AXI_RRESP,
    input  logic                      AXI_RVALID,
    output logic                      AXI_RREADY
);

    localparam int unsigned SW = AXI_DWIDTH / 8;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_READ_A = 2'd2,
        S_READ_D = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  b_done_q, b_done_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  mem_ready_d, mem_done_d, mem_err_d;
    logic [AXI_DWIDTH-1:0] mem_rdata_d;
    logic [AXI_AWIDTH-1:0] awaddr_d, araddr_d;
    logic [AXI_DWIDTH-1:0] wdata_d;
    logic [SW-1:0]         wstrb_d;
    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    logic                  tout;
    logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                  aw_all, w_all, b_all;

    // Timeout fires on the last allowed cycle; a zero limit disables it
    always_comb begin
        tout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_done_d    = b_done_q;
        err_d       = err_q;
        cnt_d       = (state_q != S_IDLE) ? cnt_q + CW'(1) : cnt_q;
        mem_done_d  = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = mem_rdata;
        awaddr_d    = AXI_AWADDR;
        araddr_d    = AXI_ARADDR;
        wdata_d     = AXI_WDATA;
        wstrb_d     = AXI_WSTRB;
        awvalid_d   = AXI_AWVALID;
        wvalid_d    = AXI_WVALID;
        bready_d    = AXI_BREADY;
        arvalid_d   = AXI_ARVALID;
        rready_d    = AXI_RREADY;

        aw_fire = AXI_AWVALID & AXI_AWREADY;
        w_fire  = AXI_WVALID  & AXI_WREADY;
        b_fire  = AXI_BREADY  & AXI_BVALID;
        ar_fire = AXI_ARVALID & AXI_ARREADY;
        r_fire  = AXI_RREADY  & AXI_RVALID;
        aw_all  = aw_done_q | aw_fire;
        w_all   = w_done_q  | w_fire;
        b_all   = b_done_q  | b_fire;

        case (state_q)
            S_IDLE: begin
                if (mem_valid && mem_ready) begin
                    awaddr_d  = mem_addr;
                    araddr_d  = mem_addr;
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_done_d  = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    if (mem_we) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = S_READ_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (b_fire) begin
                    b_done_d = 1'b1;
                    err_d    = (AXI_BRESP != 2'b00);
                end
                // Completion includes handshakes landing this cycle and beats timeout
                if (aw_all && w_all && b_all) begin
                    state_d    = S_IDLE;
                    mem_done_d = 1'b1;
                    mem_err_d  = b_fire ? (AXI_BRESP != 2'b00) : err_q;
                    awvalid_d  = 1'b0;
                    wvalid_d   = 1'b0;
                    bready_d   = 1'b0;
                end else if (tout) begin
                    state_d    = S_IDLE;
                    mem_done_d = 1'b1;
                    mem_err_d  = 1'b1;
                    awvalid_d  = 1'b0;
                    wvalid_d   = 1'b0;
                    bready_d   = 1'b0;
                end
            end
            S_READ_A: begin
                // R data seen alongside the AR handshake waits for READ_D
                if (tout) begin
                    state_d    = S_IDLE;
                    mem_done_d = 1'b1;
                    mem_err_d  = 1'b1;
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b0;
                end else if (ar_fire) begin
                    state_d   = S_READ_D;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_READ_D: begin
                if (r_fire) begin
                    state_d     = S_IDLE;
                    mem_done_d  = 1'b1;
                    mem_err_d   = (AXI_RRESP != 2'b00);
                    mem_rdata_d = AXI_RDATA;
                    rready_d    = 1'b0;
                end else if (tout) begin
                    state_d    = S_IDLE;
                    mem_done_d = 1'b1;
                    mem_err_d  = 1'b1;
                    rready_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            state_q     <= S_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_ready   <= 1'b0;
            mem_done    <= 1'b0;
            mem_err     <= 1'b0;
            mem_rdata   <= '0;
            AXI_AWADDR  <= '0;
            AXI_ARADDR  <= '0;
            AXI_WDATA   <= '0;
            AXI_WSTRB   <= '0;
            AXI_AWVALID <= 1'b0;
            AXI_WVALID  <= 1'b0;
            AXI_BREADY  <= 1'b0;
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_done_q    <= b_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_ready   <= mem_ready_d;
            mem_done    <= mem_done_d;
            mem_err     <= mem_err_d;
            mem_rdata   <= mem_rdata_d;
            AXI_AWADDR  <= awaddr_d;
            AXI_ARADDR  <= araddr_d;
            AXI_WDATA   <= wdata_d;
            AXI_WSTRB   <= wstrb_d;
            AXI_AWVALID <= awvalid_d;
            AXI_WVALID  <= wvalid_d;
            AXI_BREADY  <= bready_d;
            AXI_ARVALID <= arvalid_d;
            AXI_RREADY  <= rready_d;
        end
    end

endmodule

// File: tb/tb_axi_lsu_master.sv
// Bench for axi_lsu_master (TIMEOUT_CYCLES=16): directed plus randomized
// transactions against a scripted slave; expectations come from a cycle-level
// reference of the completion/timeout rules.
module tb_axi_lsu_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_ready, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_done, mem_err;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_rdata = '0;

    axi_lsu_master #(
        .AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
    endtask

    // Cycle c counts from the first cycle after acceptance. The slave raises
    // AWREADY/WREADY/ARREADY at exactly one scripted cycle, pulses BVALID for one
    // cycle, and holds RVALID from r_at until it is consumed.
    task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input int aw_at, input int w_at, input int b_at,
                           input int ar_at, input int r_at,
                           input logic [1:0] resp, input logic [31:0] rd);
        int fin, exp_done, done_c, n_aw, n_w, n_b, n_ar, n_r;
        bit tmo, exp_err, r_taken, got_err;
        logic [31:0] got_rd;
        logic [4:0]  vr_done;
        logic        rdy_done;

        // Reference: cycle of the final handshake, then done one cycle later
        if (we) fin = max2(max2(aw_at, w_at), b_at);
        else    fin = (ar_at < 0 || r_at < 0) ? 1000 : max2(r_at, ar_at + 1);
        tmo      = (fin > T - 1);
        exp_done = tmo ? T : fin + 1;
        exp_err  = tmo || (resp != 2'b00);
        if (!we && !tmo) model_rdata = rd;

        chk({name, ":ready"}, 64'(mem_ready), 64'd1);
        mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;

        done_c = -1; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; r_taken = 1'b0;
        got_err = 1'b0; got_rd = '0; vr_done = '1; rdy_done = 1'b0;
        for (int c = 0; c <= T + 4 && done_c < 0; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 0) begin
                if (we) chk({name, ":first_valid"}, {61'd0, awvalid, wvalid, bready}, 64'h7);
                else    chk({name, ":first_valid"}, {61'd0, arvalid, awvalid, wvalid}, 64'h4);
                chk({name, ":addr"}, 64'(we ? awaddr : araddr), 64'(addr));
            end
            awready = (c == aw_at);
            wready  = (c == w_at);
            bvalid  = (c == b_at);
            bresp   = (c == b_at) ? resp : 2'b00;
            arready = (c == ar_at);
            rvalid  = !we && r_at >= 0 && c >= r_at && !r_taken;
            rdata   = rvalid ? rd : $urandom;
            rresp   = rvalid ? resp : 2'b00;
            if (awvalid && awready) n_aw++;
            if (wvalid && wready)   n_w++;
            if (bvalid && bready)   n_b++;
            if (arvalid && arready) n_ar++;
            if (rvalid && rready) begin n_r++; r_taken = 1'b1; end
            if (mem_done) begin
                done_c   = c;
                got_err  = mem_err;
                got_rd   = mem_rdata;
                vr_done  = {awvalid, wvalid, bready, arvalid, rready};
                rdy_done = mem_ready;
            end
        end
        slave_idle();

        chk({name, ":done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({name, ":err"}, 64'(got_err), 64'(exp_err));
        chk({name, ":rdata"}, 64'(got_rd), 64'(model_rdata));
        chk({name, ":valids_at_done"}, 64'(vr_done), 64'd0);
        chk({name, ":ready_at_done"}, 64'(rdy_done), 64'd1);
        if (we) chk({name, ":hs_counts"}, {n_aw[15:0], n_w[15:0], n_b[15:0], n_ar[15:0]},
                    {16'd1, 16'd1, 16'(tmo ? 0 : 1), 16'd0});
        else    chk({name, ":hs_counts"}, {n_aw[15:0], n_w[15:0], n_ar[15:0], n_r[15:0]},
                    {16'd0, 16'd0, 16'((ar_at >= 0 && ar_at <= T - 1) ? 1 : 0), 16'(tmo ? 0 : 1)});
        if (we) chk({name, ":wpayload"}, {28'd0, wstrb, wdata}, {28'd0, strb, wd});

        @(posedge clk); #1;
        chk({name, ":done_pulse"}, {62'd0, mem_done, mem_err}, 64'd0);
        chk({name, ":quiet_after"}, {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {57'd0, mem_ready, mem_done, mem_err, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        chk("reset_data", {mem_rdata, awaddr}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_txn("st_handler", 1'b1, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF, 1, 1, 1, -1, -1, 2'b00, 32'h0);
        run_txn("st_w_early", 1'b1, 32'hF000_0004, 32'h0000_0001, 4'h1, 3, 0, 5, -1, -1, 2'b00, 32'h0);
        run_txn("ld_basic",   1'b0, 32'h0000_1000, 32'h0, 4'h0, -1, -1, -1, 2, 3, 2'b00, 32'h1234_5678);
        run_txn("ld_noready", 1'b0, 32'h0000_2000, 32'h0, 4'h0, -1, -1, -1, -1, -1, 2'b00, 32'h0);
        run_txn("st_slverr",  1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'h3, 0, 0, 0, -1, -1, 2'b10, 32'h0);
        run_txn("st_b_last",  1'b1, 32'h0000_3004, 32'h1111_2222, 4'hC, 2, 4, T - 1, -1, -1, 2'b01, 32'h0);
        run_txn("st_b_late",  1'b1, 32'h0000_3008, 32'h3333_4444, 4'hF, 2, 4, T, -1, -1, 2'b00, 32'h0);
        run_txn("ld_r_same",  1'b0, 32'h0000_4000, 32'h0, 4'h0, -1, -1, -1, 1, 1, 2'b00, 32'hCAFE_F00D);
        run_txn("ld_decerr",  1'b0, 32'h0000_5000, 32'h0, 4'h0, -1, -1, -1, 0, 0, 2'b11, 32'h0BAD_0BAD);

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            bit we;
            int aw_at, w_at, b_at, ar_at, r_at;
            logic [1:0] resp;
            we    = 1'($urandom_range(0, 1));
            resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            aw_at = $urandom_range(0, 5);
            w_at  = $urandom_range(0, 5);
            b_at  = max2(aw_at, w_at) + $urandom_range(0, 4) + (($urandom_range(0, 5) == 0) ? 12 : 0);
            ar_at = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
            r_at  = (ar_at < 0) ? -1 : ar_at + $urandom_range(0, 4) + (($urandom_range(0, 5) == 0) ? 12 : 0);
            if (we) run_txn("rnd_st", 1'b1, $urandom, $urandom, 4'($urandom), aw_at, w_at, b_at, -1, -1, resp, 32'h0);
            else    run_txn("rnd_ld", 1'b0, $urandom, 32'h0, 4'h0, -1, -1, -1, ar_at, r_at, resp, $urandom);
        end

        // Reset asserted in the middle of a write
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_6000; mem_wdata = 32'h7777_7777; mem_wstrb = 4'hF;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outs", {57'd0, mem_ready, mem_done, mem_err, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        chk("midrst_data", {mem_rdata, awaddr}, 64'd0);
        model_rdata = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release", {62'd0, mem_ready, mem_done}, 64'h2);
        run_txn("post_reset", 1'b0, 32'h0000_7000, 32'h0, 4'h0, -1, -1, -1, 0, 2, 2'b00, 32'h5555_AAAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_lsu_master.md
Name: axi_lsu_master

Overview:
AXI4-Lite master bridging the RV32I core's load/store port onto the AXI bus that feeds downstream slaves, including the signature/stop-sim file handler at 0xF0000000/0xF0000004. It accepts one core memory request at a time and issues the matching AXI write (AW+W, then B) or read (AR, then R) transaction. It returns read data and an error flag to the core with a one-cycle done pulse. A response timeout keeps the core from hanging on slaves that never answer, such as read-less slaves with ARREADY tied low.

Parameters:
AXI_AWIDTH  32  address width
AXI_DWIDTH  32  data width; strobe width = AXI_DWIDTH/8
TIMEOUT_CYCLES  1024  cycles allowed per transaction before abort; 0 disables timeout

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  reset; synchronous, active-low
mem_valid  in  1  core request valid; held until accepted
mem_ready  out  1  high in IDLE; request accepted when mem_valid & mem_ready
mem_we  in  1  1 = store, 0 = load
mem_addr  in  AXI_AWIDTH  byte address
mem_wdata  in  AXI_DWIDTH  store data
mem_wstrb  in  AXI_DWIDTH/8  store byte enables
mem_rdata  out  AXI_DWIDTH  load data; valid with mem_done
mem_done  out  1  one-cycle completion pulse
mem_err  out  1  valid with mem_done; 1 = nonzero BRESP/RRESP or timeout
AXI_AWADDR, AXI_AWVALID / AXI_AWREADY  out / in  AXI_AWIDTH, 1 / 1  write address channel
AXI_WDATA, AXI_WSTRB, AXI_WVALID / AXI_WREADY  out / in  AXI_DWIDTH, AXI_DWIDTH/8, 1 / 1  write data channel
AXI_BRESP, AXI_BVALID / AXI_BREADY  in / out  2, 1 / 1  write response channel
AXI_ARADDR, AXI_ARVALID / AXI_ARREADY  out / in  AXI_AWIDTH, 1 / 1  read address channel
AXI_RDATA, AXI_RRESP, AXI_RVALID / AXI_RREADY  in / out  AXI_DWIDTH, 2, 1 / 1  read data channel

Behaviour:
- Reset (ARESETN=0 at posedge): state=IDLE; all VALID/READY outputs 0; mem_done=0; mem_err=0; mem_rdata=0; AXI addr/data/strb=0; timeout counter=0. Reset asserted mid-transaction aborts it immediately, with no done pulse.
- All outputs are registered; mem_ready = (state==IDLE).
- IDLE: on accept, latch addr/wdata/wstrb onto the AXI outputs; clear aw_done/w_done/b_done and the counter. Store -> WRITE with AWVALID=WVALID=BREADY=1 in the next cycle. Load -> READ_A with ARVALID=1.
- WRITE: AWVALID and WVALID are raised together.
  - Each drops the cycle after its own handshake and sets aw_done/w_done.
  - BREADY stays high for the whole WRITE state. A B handshake in the same cycle as the AW/W handshakes is legal and required, since the file handler pulses BVALID for exactly one cycle together with its readies. It sets b_done and latches err = (BRESP!=0).
  - When aw_done & w_done & b_done (including flags set this cycle): next cycle mem_done=1, BREADY=0, state=IDLE.
- READ_A: ARVALID held until ARREADY; on handshake ARVALID=0, RREADY=1, state=READ_D. An RVALID arriving in the same cycle as the AR handshake is not consumed until READ_D.
- READ_D: on RVALID & RREADY, latch mem_rdata=RDATA and err=(RRESP!=0); next cycle mem_done=1, RREADY=0, state=IDLE.
- Latency: first VALID appears 1 cycle after accept; mem_done appears 1 cycle after the final handshake.
- mem_done and mem_err are high for exactly one cycle. mem_rdata holds its value until the next load completes; stores leave it unchanged.
- Timeout:
  - The counter increments every cycle outside IDLE.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without completion, all VALID/READY are deasserted next cycle, mem_done=1, mem_err=1, state=IDLE.
  - If completion and timeout occur in the same cycle, completion wins and mem_err reflects the response.
- A new request may be accepted in the same cycle that mem_done is high, because the state is already IDLE. There is no back-to-back pipelining beyond that.

Test Plan:
- Store 0xDEADBEEF, wstrb 0xF, to 0xF0000000; slave raises AW/W ready and BVALID together one cycle after valid -> exactly one AW and one W handshake; mem_done 1 cycle later with mem_err=0; VALIDs low afterwards (no duplicate write).
- Store where the slave asserts WREADY 3 cycles before AWREADY and BVALID comes 2 cycles after AW -> WVALID drops after its own handshake; single mem_done after B; mem_err=0.
- Load 0x00001000; slave returns ARREADY after 2 cycles and RDATA 0x12345678 with RRESP 0 after 1 more cycle -> mem_rdata=0x12345678, mem_done pulse, mem_err=0.
- Load from a slave with ARREADY tied 0, TIMEOUT_CYCLES=16 -> ARVALID drops and mem_done=mem_err=1 16 cycles after ARVALID first rises; next request is accepted.
- Store with BRESP=2'b10 -> mem_err=1 on done. Separately, assert reset mid-WRITE -> all outputs 0 next cycle, no mem_done, mem_ready=1 after reset release.
